// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decode plus a shift-add multiply unit writing HI/LO.
// The unit interlocks mult/mfhi/mflo through stall_o while a multiply is in flight.
//   state | meaning
//   IDLE  | waiting for a mult/multu issue
//   BUSY  | one shift-add step per cycle for DATA_W cycles
//   DONE  | sign fix-up, HI/LO written at the end of this cycle
module alu_ctrl_mdu #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 2,
  parameter int CTRL_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               flush_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [5:0]         funct_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               stall_o,
  output logic               mdu_busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic                neg;
  logic [DATA_W-1:0]   hi, lo;

  logic                r_type, is_mul, is_mf, signed_op;
  logic [DATA_W-1:0]   mag1, mag2;

  always_comb begin
    ALUCtrl_o = '0;
    if (ALUOp_i == ALUOP_W'(0))      ALUCtrl_o = CTRL_W'(4'b0010);
    else if (ALUOp_i == ALUOP_W'(1)) ALUCtrl_o = CTRL_W'(4'b0111);
    else if (ALUOp_i == ALUOP_W'(2)) ALUCtrl_o = CTRL_W'(4'b0110);
    else if (ALUOp_i == ALUOP_W'(3)) begin
      case (funct_i)
        6'd24, 6'd25: ALUCtrl_o = CTRL_W'(4'b0011);
        6'd32:        ALUCtrl_o = CTRL_W'(4'b0010);
        6'd34:        ALUCtrl_o = CTRL_W'(4'b0110);
        6'd36:        ALUCtrl_o = CTRL_W'(4'b0000);
        6'd37:        ALUCtrl_o = CTRL_W'(4'b0001);
        6'd38:        ALUCtrl_o = CTRL_W'(4'b1111);
        6'd42:        ALUCtrl_o = CTRL_W'(4'b0111);
        6'd16:        ALUCtrl_o = CTRL_W'(4'b1000);
        6'd18:        ALUCtrl_o = CTRL_W'(4'b1001);
        default:      ALUCtrl_o = '0;
      endcase
    end
  end

  assign r_type    = valid_i && (ALUOp_i == ALUOP_W'(3));
  assign is_mul    = r_type && ((funct_i == 6'd24) || (funct_i == 6'd25));
  assign is_mf     = r_type && ((funct_i == 6'd16) || (funct_i == 6'd18));
  assign signed_op = (funct_i == 6'd24);

  // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
  assign mag1 = (signed_op && src1_i[DATA_W-1]) ? (~src1_i + 1'b1) : src1_i;
  assign mag2 = (signed_op && src2_i[DATA_W-1]) ? (~src2_i + 1'b1) : src2_i;

  always_comb begin
    state_nx   = state;
    stall_o    = 1'b0;
    mdu_busy_o = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul && !flush_i) begin
          state_nx = BUSY;
          stall_o  = 1'b1;
        end
      end
      BUSY: begin
        stall_o    = 1'b1;
        mdu_busy_o = 1'b1;
        if (flush_i)                        state_nx = IDLE;
        else if (cnt == CNT_W'(DATA_W - 1)) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        stall_o  = is_mf;
        done_o   = !flush_i;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (is_mul && !flush_i) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, mag1};
            mplier <= mag2;
            neg    <= signed_op && (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (!flush_i) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!flush_i) {hi, lo} <= neg ? (~acc + 1'b1) : acc;
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: decode table, directed and random multiplies against
// a plain-arithmetic product model, plus interlock, flush and reset sequences.
module tb_alu_ctrl_mdu;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i, valid_i, flush_i;
  logic [1:0]   ALUOp_i;
  logic [5:0]   funct_i;
  logic [W-1:0] src1_i, src2_i;
  logic [3:0]   ALUCtrl_o;
  logic         stall_o, mdu_busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  alu_ctrl_mdu #(.DATA_W(W), .ALUOP_W(2), .CTRL_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .ALUCtrl_o(ALUCtrl_o), .stall_o(stall_o), .mdu_busy_o(mdu_busy_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_hi, exp_lo;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] code;
  } dec_vec_t;
  dec_vec_t dv[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0111;
    if (op == 2'd2) return 4'b0110;
    case (fn)
      6'd24, 6'd25: return 4'b0011;
      6'd32: return 4'b0010;
      6'd34: return 4'b0110;
      6'd36: return 4'b0000;
      6'd37: return 4'b0001;
      6'd38: return 4'b1111;
      6'd42: return 4'b0111;
      6'd16: return 4'b1000;
      6'd18: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [63:0] ref_mul(input bit is_signed, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (is_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Issues a multiply and holds it until done_o; returns at the negedge of the DONE cycle.
  task automatic run_mul(input string name, input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    int done_at;
    bit stall_ok, busy_ok;
    logic [63:0] p;
    done_at = -1;
    stall_ok = 1;
    busy_ok = 1;
    p = ref_mul(fn == 6'd24, a, b);
    @(posedge clk_i); #1;
    valid_i = 1; ALUOp_i = 2'd3; funct_i = fn; src1_i = a; src2_i = b;
    for (int c = 0; c <= W + 8; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        chk({name, " hi before"}, 64'(hi_o), 64'(exp_hi));
        chk({name, " lo before"}, 64'(lo_o), 64'(exp_lo));
      end
      if (done_o === 1'b1) begin
        done_at = c;
        break;
      end
      if (stall_o !== 1'b1) stall_ok = 0;
      if (mdu_busy_o !== (c >= 1)) busy_ok = 0;
    end
    chk({name, " done cycle"}, 64'(done_at), 64'(W + 1));
    chk({name, " stall while busy"}, 64'(stall_ok), 64'd1);
    chk({name, " busy flag"}, 64'(busy_ok), 64'd1);
    chk({name, " stall in DONE"}, 64'(stall_o), 64'd0);
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  task automatic finish_mul(input string name);
    @(posedge clk_i); #1;
    valid_i = 0;
    @(negedge clk_i);
    chk({name, " hi"}, 64'(hi_o), 64'(exp_hi));
    chk({name, " lo"}, 64'(lo_o), 64'(exp_lo));
    chk({name, " no restart"}, 64'(mdu_busy_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int free_at, saw_done;
    bit any_done;
    logic [63:0] p;
    logic [5:0] fnl [12];

    dv[0]  = '{2'd0, 6'h3F, 4'b0010};
    dv[1]  = '{2'd1, 6'h3F, 4'b0111};
    dv[2]  = '{2'd2, 6'h3F, 4'b0110};
    dv[3]  = '{2'd0, 6'd24, 4'b0010};
    dv[4]  = '{2'd3, 6'd24, 4'b0011};
    dv[5]  = '{2'd3, 6'd25, 4'b0011};
    dv[6]  = '{2'd3, 6'd32, 4'b0010};
    dv[7]  = '{2'd3, 6'd34, 4'b0110};
    dv[8]  = '{2'd3, 6'd36, 4'b0000};
    dv[9]  = '{2'd3, 6'd37, 4'b0001};
    dv[10] = '{2'd3, 6'd38, 4'b1111};
    dv[11] = '{2'd3, 6'd42, 4'b0111};
    dv[12] = '{2'd3, 6'd16, 4'b1000};
    dv[13] = '{2'd3, 6'd18, 4'b1001};
    dv[14] = '{2'd3, 6'h3F, 4'b0000};
    dv[15] = '{2'd3, 6'd0,  4'b0000};
    fnl = '{6'd24, 6'd25, 6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd42, 6'd16, 6'd18, 6'd0, 6'h3F};

    rst_i = 1; valid_i = 0; flush_i = 0; ALUOp_i = 0; funct_i = 0; src1_i = 0; src2_i = 0;
    exp_hi = 0; exp_lo = 0;
    #2;
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    chk("reset busy", 64'(mdu_busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset stall", 64'(stall_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk_i); #1;
      ALUOp_i = dv[i].op; funct_i = dv[i].fn;
      @(negedge clk_i);
      chk($sformatf("decode op%0d fn%0d", dv[i].op, dv[i].fn), 64'(ALUCtrl_o), 64'(dv[i].code));
    end
    for (int i = 0; i < 24; i++) begin
      @(posedge clk_i); #1;
      ALUOp_i = 2'($urandom_range(0, 3));
      funct_i = (i % 3 == 0) ? 6'($urandom) : fnl[$urandom_range(0, 11)];
      @(negedge clk_i);
      chk($sformatf("rand decode op%0d fn%0d", ALUOp_i, funct_i), 64'(ALUCtrl_o), 64'(ref_ctrl(ALUOp_i, funct_i)));
    end

    run_mul("multu 7x6", 6'd25, 32'd7, 32'd6);
    finish_mul("multu 7x6");
    chk("multu 7x6 lo literal", 64'(lo_o), 64'h2A);
    run_mul("mult -3x5", 6'd24, 32'hFFFFFFFD, 32'd5);
    finish_mul("mult -3x5");
    chk("mult -3x5 lo literal", 64'(lo_o), 64'hFFFFFFF1);
    run_mul("mult min x min", 6'd24, 32'h80000000, 32'h80000000);
    finish_mul("mult min x min");
    chk("mult min x min hi literal", 64'(hi_o), 64'h40000000);
    run_mul("multu max x max", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_mul("multu max x max");
    chk("multu max x max hi literal", 64'(hi_o), 64'hFFFFFFFE);

    // Back-to-back: second issue lands on the cycle right after DONE.
    run_mul("b2b first", 6'd24, 32'd123456, 32'hFFFFF000);
    run_mul("b2b second", 6'd25, 32'hDEADBEEF, 32'h01234567);
    finish_mul("b2b second");

    // mflo arriving while the multiply is busy.
    p = ref_mul(1'b1, 32'd1234, 32'hFFFFFFF7);
    @(posedge clk_i); #1;
    valid_i = 1; ALUOp_i = 2'd3; funct_i = 6'd24; src1_i = 32'd1234; src2_i = 32'hFFFFFFF7;
    @(posedge clk_i); #1;
    funct_i = 6'd18;
    free_at = -1; saw_done = -1;
    for (int c = 1; c <= W + 8; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) saw_done = c;
      if (stall_o !== 1'b1) begin
        free_at = c;
        break;
      end
    end
    chk("mflo done cycle", 64'(saw_done), 64'(W + 1));
    chk("mflo release cycle", 64'(free_at), 64'(W + 2));
    chk("mflo ctrl", 64'(ALUCtrl_o), 64'b1001);
    chk("mflo new lo", 64'(lo_o), 64'(p[31:0]));
    chk("mflo new hi", 64'(hi_o), 64'(p[63:32]));
    exp_hi = p[63:32]; exp_lo = p[31:0];
    @(posedge clk_i); #1 valid_i = 0;

    run_mul("preload", 6'd25, 32'd1722007169, 32'd714156689);
    finish_mul("preload");
    chk("preload hi literal", 64'(hi_o), 64'h11111111);
    chk("preload lo literal", 64'(lo_o), 64'h11111111);

    // Flush on BUSY cycle 10.
    @(posedge clk_i); #1;
    valid_i = 1; ALUOp_i = 2'd3; funct_i = 6'd25; src1_i = 32'd7; src2_i = 32'd6;
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1; valid_i = 0;
    @(negedge clk_i);
    chk("flush cycle done", 64'(done_o), 64'd0);
    @(posedge clk_i); #1 flush_i = 0;
    @(negedge clk_i);
    chk("flush idle busy", 64'(mdu_busy_o), 64'd0);
    chk("flush idle stall", 64'(stall_o), 64'd0);
    any_done = 0;
    for (int c = 0; c < W + 8; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) any_done = 1;
    end
    chk("flush no done", 64'(any_done), 64'd0);
    chk("flush hi kept", 64'(hi_o), 64'h11111111);
    chk("flush lo kept", 64'(lo_o), 64'h11111111);

    // Reset on BUSY cycle 5.
    @(posedge clk_i); #1;
    valid_i = 1; ALUOp_i = 2'd3; funct_i = 6'd24; src1_i = 32'd99; src2_i = 32'd77;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1; valid_i = 0;
    #1;
    chk("midrst hi", 64'(hi_o), 64'd0);
    chk("midrst lo", 64'(lo_o), 64'd0);
    chk("midrst busy", 64'(mdu_busy_o), 64'd0);
    chk("midrst done", 64'(done_o), 64'd0);
    chk("midrst stall", 64'(stall_o), 64'd0);
    @(posedge clk_i); #1 rst_i = 0;
    exp_hi = 0; exp_lo = 0;

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a, b;
      logic [5:0] fn;
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'h80000000;
      if (i == 1) b = 32'd0;
      fn = ($urandom_range(0, 1) == 0) ? 6'd24 : 6'd25;
      run_mul($sformatf("rand%0d fn%0d", i, fn), fn, a, b);
      finish_mul($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
